// File: rtl/core_id_alu_dec.sv
// core_id_alu_dec: RV32I decode stage feeding the ID/EX register of the EX-stage ALU.
// Optional macro CORE_ID_SKID_EN adds a one-entry skid buffer with a registered in_ready.
`default_nettype none

module core_id_alu_dec #(
    parameter int XLEN  = 32,
    parameter int ALU_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ALU_W-1:0]  out_alu_inst_bus,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_rs1_addr,
    output logic [4:0]        out_rs2_addr,
    output logic [4:0]        out_rd_addr,
    output logic              out_rd_wen,
    output logic              out_illegal
);

    localparam int c_ADD     = 0;
    localparam int c_SUB     = 1;
    localparam int c_CMP     = 2;
    localparam int c_CMP_U   = 3;
    localparam int c_SLL     = 4;
    localparam int c_SRL     = 5;
    localparam int c_SRA     = 6;
    localparam int c_OR      = 7;
    localparam int c_AND     = 8;
    localparam int c_XOR     = 9;
    localparam int c_OP1_PC  = 10;
    localparam int c_OP2_IMM = 11;
    localparam int c_RS2_LSB = 12;

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [ALU_W-1:0] bus;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             rd_wen;
        logic             illegal;
    } dec_t;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm32;
    logic        w_f7_ok;
    dec_t        w_dec;
    logic        w_accept;

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'b0};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Register-register ops: funct7 must be zero, except 0100000 for SUB and SRA.
    assign w_f7_ok = (w_f7 == 7'b0000000) ||
                     ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));

    always_comb begin
        w_dec         = '0;
        w_imm32       = '0;
        w_dec.pc      = in_pc;
        w_dec.rs1     = in_instr[19:15];
        w_dec.rs2     = in_instr[24:20];
        w_dec.rd      = in_instr[11:7];
        w_dec.rd_wen  = 1'b0;
        w_dec.illegal = 1'b0;
        case (w_opc)
            c_OPC_LUI: begin
                w_dec.bus[c_ADD]     = 1'b1;
                w_dec.bus[c_OP2_IMM] = 1'b1;
                w_dec.rs1            = 5'd0;
                w_imm32              = w_imm_u;
                w_dec.rd_wen         = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_dec.bus[c_ADD]     = 1'b1;
                w_dec.bus[c_OP1_PC]  = 1'b1;
                w_dec.bus[c_OP2_IMM] = 1'b1;
                w_imm32              = w_imm_u;
                w_dec.rd_wen         = 1'b1;
            end
            // Jumps: EX forms the link address pc+4; the target uses the immediate elsewhere.
            c_OPC_JAL: begin
                w_dec.bus[c_ADD]    = 1'b1;
                w_dec.bus[c_OP1_PC] = 1'b1;
                w_imm32             = w_imm_j;
                w_dec.rd_wen        = 1'b1;
            end
            c_OPC_JALR: begin
                w_dec.bus[c_ADD]    = 1'b1;
                w_dec.bus[c_OP1_PC] = 1'b1;
                w_imm32             = w_imm_i;
                w_dec.rd_wen        = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_imm32 = w_imm_b;
                case (w_f3)
                    3'b000, 3'b001: w_dec.bus[c_SUB]   = 1'b1;
                    3'b100, 3'b101: w_dec.bus[c_CMP]   = 1'b1;
                    3'b110, 3'b111: w_dec.bus[c_CMP_U] = 1'b1;
                    default:        w_dec.illegal      = 1'b1;
                endcase
            end
            c_OPC_LOAD: begin
                w_dec.bus[c_ADD]     = 1'b1;
                w_dec.bus[c_OP2_IMM] = 1'b1;
                w_imm32              = w_imm_i;
                w_dec.rd_wen         = 1'b1;
            end
            c_OPC_STORE: begin
                w_dec.bus[c_ADD]     = 1'b1;
                w_dec.bus[c_OP2_IMM] = 1'b1;
                w_imm32              = w_imm_s;
            end
            c_OPC_OPIMM: begin
                w_dec.bus[c_OP2_IMM] = 1'b1;
                w_imm32              = w_imm_i;
                w_dec.rd_wen         = 1'b1;
                case (w_f3)
                    3'b000: w_dec.bus[c_ADD]   = 1'b1;
                    3'b010: w_dec.bus[c_CMP]   = 1'b1;
                    3'b011: w_dec.bus[c_CMP_U] = 1'b1;
                    3'b100: w_dec.bus[c_XOR]   = 1'b1;
                    3'b110: w_dec.bus[c_OR]    = 1'b1;
                    3'b111: w_dec.bus[c_AND]   = 1'b1;
                    3'b001: begin
                        w_dec.illegal                     = in_instr[25];
                        w_dec.bus[c_SLL]                  = 1'b1;
                        w_dec.bus[c_RS2_LSB +: 5]         = in_instr[24:20];
                    end
                    default: begin
                        w_dec.illegal                     = in_instr[25];
                        w_dec.bus[c_SRA]                  = in_instr[30];
                        w_dec.bus[c_SRL]                  = ~in_instr[30];
                        w_dec.bus[c_RS2_LSB +: 5]         = in_instr[24:20];
                    end
                endcase
            end
            c_OPC_OP: begin
                w_dec.rd_wen  = 1'b1;
                w_dec.illegal = ~w_f7_ok;
                case (w_f3)
                    3'b000: begin
                        w_dec.bus[c_SUB] = in_instr[30];
                        w_dec.bus[c_ADD] = ~in_instr[30];
                    end
                    3'b001: w_dec.bus[c_SLL]   = 1'b1;
                    3'b010: w_dec.bus[c_CMP]   = 1'b1;
                    3'b011: w_dec.bus[c_CMP_U] = 1'b1;
                    3'b100: w_dec.bus[c_XOR]   = 1'b1;
                    3'b101: begin
                        w_dec.bus[c_SRA] = in_instr[30];
                        w_dec.bus[c_SRL] = ~in_instr[30];
                    end
                    3'b110: w_dec.bus[c_OR]    = 1'b1;
                    default: w_dec.bus[c_AND]  = 1'b1;
                endcase
            end
            default: w_dec.illegal = 1'b1;
        endcase
        if (w_dec.illegal) begin
            w_dec.bus    = '0;
            w_imm32      = '0;
            w_dec.rd_wen = 1'b0;
        end
        if (w_dec.rd == 5'd0) begin
            w_dec.rd_wen = 1'b0;
        end
        w_dec.imm = XLEN'($signed(w_imm32));
    end

    dec_t r_out;
    logic r_valid;

    assign w_accept = in_valid & in_ready & ~flush;

`ifdef CORE_ID_SKID_EN
    dec_t r_skid;
    logic r_skid_valid;

    // in_ready depends only on skid occupancy, so out_ready never reaches fetch combinationally.
    assign in_ready = ~r_skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_out        <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_valid      <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out   <= w_dec;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = ~r_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_out   <= w_dec;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

    assign out_valid        = r_valid;
    assign out_alu_inst_bus = r_out.bus;
    assign out_pc           = r_out.pc;
    assign out_imm          = r_out.imm;
    assign out_rs1_addr     = r_out.rs1;
    assign out_rs2_addr     = r_out.rs2;
    assign out_rd_addr      = r_out.rd;
    assign out_rd_wen       = r_out.rd_wen;
    assign out_illegal      = r_out.illegal;

endmodule

`default_nettype wire

// File: tb/tb_core_id_alu_dec.sv
// tb_core_id_alu_dec: directed self-checking bench for core_id_alu_dec.
`default_nettype none

module tb_core_id_alu_dec;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_alu_inst_bus;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1_addr;
    logic [4:0]  out_rs2_addr;
    logic [4:0]  out_rd_addr;
    logic        out_rd_wen;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    core_id_alu_dec #(.XLEN(32), .ALU_W(17)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instr         (in_instr),
        .in_pc            (in_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_alu_inst_bus (out_alu_inst_bus),
        .out_pc           (out_pc),
        .out_imm          (out_imm),
        .out_rs1_addr     (out_rs1_addr),
        .out_rs2_addr     (out_rs2_addr),
        .out_rd_addr      (out_rd_addr),
        .out_rd_wen       (out_rd_wen),
        .out_illegal      (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction for one cycle with EX ready; returns at the negedge after capture.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = 1'b1;
        flush     = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h exp 0", out_valid); end
        n_checks++; if (out_alu_inst_bus !== 17'h0) begin n_fail++; $display("FAIL reset_bus got %0h exp 0", out_alu_inst_bus); end
        n_checks++; if (out_imm !== 32'h0 || out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_imm_pc got %0h/%0h exp 0/0", out_imm, out_pc); end
        n_checks++; if ({out_rs1_addr, out_rs2_addr, out_rd_addr, out_rd_wen, out_illegal} !== 17'h0) begin
            n_fail++; $display("FAIL reset_fields got %0h exp 0", {out_rs1_addr, out_rs2_addr, out_rd_addr, out_rd_wen, out_illegal}); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
    endtask

    task automatic test_alu_ops();
        send(32'h00500093, 32'h0);  // addi x1,x0,5
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %0h exp 1", out_valid); end
        n_checks++; if (out_alu_inst_bus !== 17'h00801) begin n_fail++; $display("FAIL addi_bus got %0h exp 801", out_alu_inst_bus); end
        n_checks++; if (out_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm got %0h exp 5", out_imm); end
        n_checks++; if (out_rs1_addr !== 5'd0 || out_rd_addr !== 5'd1 || out_rd_wen !== 1'b1) begin
            n_fail++; $display("FAIL addi_regs got rs1=%0d rd=%0d wen=%0d exp 0/1/1", out_rs1_addr, out_rd_addr, out_rd_wen); end

        send(32'h402081B3, 32'h4);  // sub x3,x1,x2
        n_checks++; if (out_alu_inst_bus !== 17'h00002) begin n_fail++; $display("FAIL sub_bus got %0h exp 2", out_alu_inst_bus); end
        n_checks++; if (out_rs1_addr !== 5'd1 || out_rs2_addr !== 5'd2 || out_rd_addr !== 5'd3 || out_rd_wen !== 1'b1) begin
            n_fail++; $display("FAIL sub_regs got %0d/%0d/%0d/%0d exp 1/2/3/1", out_rs1_addr, out_rs2_addr, out_rd_addr, out_rd_wen); end

        send(32'h40335293, 32'h8);  // srai x5,x6,3
        n_checks++; if (out_alu_inst_bus !== 17'h03840) begin n_fail++; $display("FAIL srai_bus got %0h exp 3840", out_alu_inst_bus); end
        n_checks++; if (out_rs1_addr !== 5'd6 || out_rd_addr !== 5'd5 || out_imm !== 32'h403) begin
            n_fail++; $display("FAIL srai_fields got rs1=%0d rd=%0d imm=%0h exp 6/5/403", out_rs1_addr, out_rd_addr, out_imm); end

        send(32'h00000013, 32'hC);  // addi x0,x0,0: no write to x0
        n_checks++; if (out_rd_wen !== 1'b0 || out_alu_inst_bus !== 17'h00801) begin
            n_fail++; $display("FAIL nop_wen got wen=%0d bus=%0h exp 0/801", out_rd_wen, out_alu_inst_bus); end
    endtask

    task automatic test_control_flow();
        send(32'h008000EF, 32'h100);  // jal x1,+8
        n_checks++; if (out_alu_inst_bus !== 17'h00401) begin n_fail++; $display("FAIL jal_bus got %0h exp 401", out_alu_inst_bus); end
        n_checks++; if (out_imm !== 32'd8 || out_pc !== 32'h100 || out_rd_wen !== 1'b1) begin
            n_fail++; $display("FAIL jal_fields got imm=%0h pc=%0h wen=%0d exp 8/100/1", out_imm, out_pc, out_rd_wen); end

        send(32'h123453B7, 32'h104);  // lui x7,0x12345
        n_checks++; if (out_alu_inst_bus !== 17'h00801 || out_imm !== 32'h12345000 || out_rs1_addr !== 5'd0 || out_rd_addr !== 5'd7) begin
            n_fail++; $display("FAIL lui got bus=%0h imm=%0h rs1=%0d rd=%0d exp 801/12345000/0/7", out_alu_inst_bus, out_imm, out_rs1_addr, out_rd_addr); end

        send(32'h0020E863, 32'h108);  // bltu x1,x2,+16
        n_checks++; if (out_alu_inst_bus !== 17'h00008 || out_imm !== 32'd16 || out_rd_wen !== 1'b0) begin
            n_fail++; $display("FAIL bltu got bus=%0h imm=%0h wen=%0d exp 8/10/0", out_alu_inst_bus, out_imm, out_rd_wen); end

        send(32'hFE000EE3, 32'h10C);  // beq x0,x0,-4
        n_checks++; if (out_alu_inst_bus !== 17'h00002 || out_imm !== 32'hFFFFFFFC) begin
            n_fail++; $display("FAIL beq_neg got bus=%0h imm=%0h exp 2/fffffffc", out_alu_inst_bus, out_imm); end

        send(32'hFE20AC23, 32'h110);  // sw x2,-8(x1)
        n_checks++; if (out_alu_inst_bus !== 17'h00801 || out_imm !== 32'hFFFFFFF8 || out_rd_wen !== 1'b0) begin
            n_fail++; $display("FAIL sw got bus=%0h imm=%0h wen=%0d exp 801/fffffff8/0", out_alu_inst_bus, out_imm, out_rd_wen); end
    endtask

    task automatic test_illegal();
        send(32'hFFFFFFFF, 32'h200);
        n_checks++; if (out_illegal !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL ill_flag got ill=%0d valid=%0d exp 1/1", out_illegal, out_valid); end
        n_checks++; if (out_alu_inst_bus !== 17'h0 || out_rd_wen !== 1'b0 || out_imm !== 32'h0) begin
            n_fail++; $display("FAIL ill_fields got bus=%0h wen=%0d imm=%0h exp 0/0/0", out_alu_inst_bus, out_rd_wen, out_imm); end

        send(32'h02009093, 32'h204);  // slli with instr[25]=1
        n_checks++; if (out_illegal !== 1'b1 || out_alu_inst_bus !== 17'h0) begin
            n_fail++; $display("FAIL ill_slli got ill=%0d bus=%0h exp 1/0", out_illegal, out_alu_inst_bus); end

        send(32'h02000033, 32'h208);  // OP with funct7=0000001
        n_checks++; if (out_illegal !== 1'b1 || out_rd_wen !== 1'b0) begin
            n_fail++; $display("FAIL ill_f7 got ill=%0d wen=%0d exp 1/0", out_illegal, out_rd_wen); end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = 32'h00500093;  // A: addi x1,x0,5
        in_pc     = 32'h300;
        out_ready = 1'b0;
        @(negedge clk);
        in_instr  = 32'h402081B3;  // B: sub x3,x1,x2
        in_pc     = 32'h304;
`ifdef CORE_ID_SKID_EN
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_skid_ready got %0d exp 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
`else
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %0d exp 0", in_ready); end
        @(negedge clk);
`endif
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_alu_inst_bus !== 17'h00801 || out_pc !== 32'h300 || out_rd_addr !== 5'd1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_stall%0d got v=%0d bus=%0h pc=%0h rd=%0d rdy=%0d exp 1/801/300/1/0",
                                   i, out_valid, out_alu_inst_bus, out_pc, out_rd_addr, in_ready); end
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_alu_inst_bus !== 17'h00002 || out_pc !== 32'h304) begin
            n_fail++; $display("FAIL bp_second got v=%0d bus=%0h pc=%0h exp 1/2/304", out_valid, out_alu_inst_bus, out_pc); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0d exp 0", out_valid); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = 32'h00500093;
        in_pc     = 32'h400;
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_capture got %0d exp 0", out_valid); end

        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_held got %0d exp 0", out_valid); end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = 32'h008000EF;
        in_pc     = 32'h500;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_alu_inst_bus !== 17'h0 || out_pc !== 32'h0) begin
            n_fail++; $display("FAIL async_rst got v=%0d bus=%0h pc=%0h exp 0/0/0", out_valid, out_alu_inst_bus, out_pc); end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_alu_ops();
        test_control_flow();
        test_illegal();
        test_back_pressure();
        test_flush();
        test_reset_mid_stall();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
